// File: rtl/slc3_mem_pkg.sv
// Shared definitions for the SLC-3 memory front end: loader states and
// default geometry of the ROM / SRAM / CPU ports.
package slc3_mem_pkg;

  localparam int DATA_W        = 16;
  localparam int DEFAULT_DEPTH = 256;
  localparam int DEFAULT_AW    = 16;

  // PRIME presents ROM address 0, LOAD streams the image, RUN serves the CPU.
  typedef enum logic [1:0] {
    PRIME = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage : slc3_mem_pkg

// File: rtl/sram_init_loader.sv
// SRAM front end for the SLC-3 CPU. Copies DEPTH words from a ROM read port
// into the SRAM after reset (or on Start), holding the CPU off, then serves
// CPU accesses with a fixed one-wait-state ready pulse.
module sram_init_loader
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  output logic [AW-1:0]     rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_oe,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdy,
  output logic              init_done
);

  // Counters carry one extra bit so DEPTH = 2**AW reaches its terminal
  // compare without wrapping.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_e            state_q, state_d;
  logic [AW:0]       rd_cnt_q, rd_cnt_d;
  logic [AW:0]       wr_cnt_q, wr_cnt_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              rd_pend_q, rd_pend_d;   // accepted access was a read
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              accept;

  // The read counter's top bit only exists to match the write counter; the
  // ROM address never needs it (the value DEPTH in the last cycle is ignored).
  logic rd_cnt_msb_unused;
  assign rd_cnt_msb_unused = rd_cnt_q[AW];

  // Next-state, counter and memory-port decode for the load / run FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    rd_pend_d = rd_pend_q;
    cpu_rdy_d = 1'b0;
    accept    = 1'b0;
    rom_addr  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    init_done = 1'b0;

    unique case (state_q)
      PRIME: begin
        // ROM word 0 is being fetched; it arrives for the first LOAD cycle.
        rd_cnt_d = CNT_ONE;
        wr_cnt_d = '0;
        state_d  = LOAD;
      end

      LOAD: begin
        // Fetch word rd_cnt while writing word wr_cnt fetched last cycle.
        rom_addr  = rd_cnt_q[AW-1:0];
        mem_we    = 1'b1;
        mem_addr  = wr_cnt_q[AW-1:0];
        mem_wdata = rom_data;
        rd_cnt_d  = rd_cnt_q + CNT_ONE;
        wr_cnt_d  = wr_cnt_q + CNT_ONE;
        if (wr_cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end

      RUN: begin
        init_done = 1'b1;
        // CPU address and data pass straight through; decode lives downstream.
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        accept    = (cpu_we | cpu_oe) & ~cpu_rdy_q;
        if (accept) begin
          // A simultaneous we/oe request is a write.
          mem_we    = cpu_we;
          cpu_rdy_d = 1'b1;
          rd_pend_d = ~cpu_we;
        end
        // An access accepted alongside Start still gets its rdy pulse, which
        // is emitted from PRIME on the next cycle.
        if (Start) begin
          state_d = PRIME;
        end
      end

      default: begin
        state_d = PRIME;
      end
    endcase
  end

  // Read data follows the SRAM only during a read's rdy cycle, else holds.
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    if (cpu_rdy_q && rd_pend_q) begin
      cpu_rdata_d = mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rdata_d;
  assign cpu_rdy   = cpu_rdy_q;

  // State, counters and ready/read-data registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= PRIME;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      cpu_rdy_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, regardless of statement order.
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      cpu_rdy_q   <= cpu_rdy_d;
      rd_pend_q   <= rd_pend_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

endmodule : sram_init_loader

// File: tb/tb_sram_init_loader.sv
// Self-checking bench for sram_init_loader with DEPTH=8. A ROM and an SRAM
// model surround the DUT; a reference model built on a load index and a
// shadow image of the SRAM is compared against the DUT on every cycle, and
// directed tests pin the model with hand-computed values.
module tb_sram_init_loader;

  localparam int DEPTH = 8;
  localparam int AW    = 16;

  logic          Clk       = 1'b0;
  logic          Reset_n   = 1'b0;
  logic          Start     = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data  = '0;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic [15:0]   mem_rdata = '0;
  logic [AW-1:0] cpu_addr  = '0;
  logic [15:0]   cpu_wdata = '0;
  logic          cpu_we    = 1'b0;
  logic          cpu_oe    = 1'b0;
  logic [15:0]   cpu_rdata;
  logic          cpu_rdy;
  logic          init_done;

  int n_total = 0;
  int n_bad   = 0;

  always #5 Clk = ~Clk;

  sram_init_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_oe    (cpu_oe),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
    .init_done (init_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM image: word i holds A000+i; out-of-range reads return a marker.
  function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
    if (32'(a) < DEPTH) return 16'hA000 + a;
    return 16'hDEAD;
  endfunction

  // ROM and SRAM: registered read, one cycle after the address.
  logic [15:0] sram   [0:255];
  logic [15:0] shadow [0:255];

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]   = '0;
      shadow[i] = '0;
    end
  end

  always @(posedge Clk) begin
    rom_data <= rom_word(rom_addr);
    if (mem_we) sram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= sram[mem_addr[7:0]];
  end

  // Reference model. ld_idx counts cycles of the load sequence: 0 is the
  // prime cycle, k in 1..DEPTH writes image word k-1, DEPTH+1 means running.
  int            ld_idx      = 0;
  logic          m_rdy       = 1'b0;
  logic          m_pend_rd   = 1'b0;
  logic [AW-1:0] m_pend_addr = '0;
  logic [15:0]   m_last_rd   = '0;
  logic          running, loading_wr, m_acc, e_we;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_wdata, e_rdata;

  always_comb begin
    running    = ld_idx > DEPTH;
    loading_wr = !running && ld_idx >= 1;
    m_acc      = running && (cpu_we || cpu_oe) && !m_rdy;
    e_we       = loading_wr || (m_acc && cpu_we);
    e_addr     = loading_wr ? AW'(ld_idx - 1) : (m_acc ? cpu_addr : '0);
    e_wdata    = loading_wr ? rom_word(AW'(ld_idx - 1)) : cpu_wdata;
    e_rdata    = (m_rdy && m_pend_rd) ? shadow[m_pend_addr[7:0]] : m_last_rd;
  end

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ld_idx    <= 0;
      m_rdy     <= 1'b0;
      m_pend_rd <= 1'b0;
      m_last_rd <= '0;
    end else begin
      m_last_rd <= e_rdata;
      if (loading_wr) shadow[(ld_idx - 1) & 255] <= rom_word(AW'(ld_idx - 1));
      if (m_acc && cpu_we) shadow[cpu_addr[7:0]] <= cpu_wdata;
      m_rdy <= m_acc;
      if (m_acc) begin
        m_pend_rd   <= !cpu_we;
        m_pend_addr <= cpu_addr;
      end
      if (running && Start) ld_idx <= 0;
      else if (!running)    ld_idx <= ld_idx + 1;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge Clk) begin
    check("init_done", 32'(init_done), 32'(running));
    check("cpu_rdy",   32'(cpu_rdy),   32'(m_rdy));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
    check("mem_we",    32'(mem_we),    32'(e_we));
    if (e_we || !running) check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    if (!running) check("rom_addr", 32'(rom_addr), 32'(AW'(ld_idx)));
    if (ld_idx == 0) check("mem_wdata_prime", 32'(mem_wdata), 32'(0));
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Follows a load from its prime cycle (cycle 1, the cycle in which reset is
  // released or the first cycle after Start) until init_done is seen.
  task automatic wait_load(output int rise, output int nwe, output int nrdy);
    rise = 0;
    nwe  = 0;
    nrdy = 0;
    for (int k = 1; k <= 40 && rise == 0; k++) begin
      @(negedge Clk);
      if (init_done) rise = k;
      else if (mem_we) nwe++;
      if (cpu_rdy) nrdy++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_done"}, 32'(init_done), 32'(0));
    check({tag, "_cpu_rdy"},   32'(cpu_rdy),   32'(0));
    check({tag, "_mem_we"},    32'(mem_we),    32'(0));
    check({tag, "_rom_addr"},  32'(rom_addr),  32'(0));
    check({tag, "_mem_addr"},  32'(mem_addr),  32'(0));
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          rise, nwe, nrdy;
    logic [3:0]  pat;
    logic [15:0] got;

    // Reset state.
    step();
    step();
    check_reset_outputs("rst");
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));

    // Initial load with a read of address 4 pending from the start.
    cpu_oe   = 1'b1;
    cpu_addr = 16'd4;
    Reset_n  = 1'b1;
    wait_load(rise, nwe, nrdy);
    check("load_init_cycle", 32'(rise), 32'(10));
    check("load_writes",     32'(nwe),  32'(8));
    check("load_rdy",        32'(nrdy), 32'(0));
    @(negedge Clk);
    check("pending_rdy",   32'(cpu_rdy),   32'(1));
    check("pending_rdata", 32'(cpu_rdata), 32'(16'hA004));
    step();
    cpu_oe = 1'b0;

    // Held read of address 3: rdy every other cycle.
    step();
    cpu_oe   = 1'b1;
    cpu_addr = 16'd3;
    pat = '0;
    got = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      pat[i] = cpu_rdy;
      if (cpu_rdy) got = cpu_rdata;
    end
    check("read_rdy_pattern", 32'(pat), 32'(4'b1010));
    check("read_rdata",       32'(got), 32'(16'hA003));
    step();
    cpu_oe = 1'b0;

    // Write with we and oe both high, then read back.
    step();
    cpu_we    = 1'b1;
    cpu_oe    = 1'b1;
    cpu_addr  = 16'd5;
    cpu_wdata = 16'h1234;
    @(negedge Clk);
    check("wr_mem_we",    32'(mem_we),    32'(1));
    check("wr_mem_addr",  32'(mem_addr),  32'(5));
    check("wr_mem_wdata", 32'(mem_wdata), 32'(16'h1234));
    step();
    cpu_we = 1'b0;
    cpu_oe = 1'b0;
    @(negedge Clk);
    check("wr_rdy",    32'(cpu_rdy), 32'(1));
    check("wr_rdy_we", 32'(mem_we),  32'(0));
    step();
    cpu_oe = 1'b1;
    @(negedge Clk);
    step();
    cpu_oe = 1'b0;
    @(negedge Clk);
    check("rdback_rdy",   32'(cpu_rdy),   32'(1));
    check("rdback_rdata", 32'(cpu_rdata), 32'(16'h1234));

    // Start in the same cycle as a read of address 2.
    step();
    cpu_oe   = 1'b1;
    cpu_addr = 16'd2;
    Start    = 1'b1;
    @(negedge Clk);
    step();
    Start = 1'b0;
    @(negedge Clk);
    check("start_rdy",       32'(cpu_rdy),   32'(1));
    check("start_rdata",     32'(cpu_rdata), 32'(16'hA002));
    check("start_init_done", 32'(init_done), 32'(0));
    wait_load(rise, nwe, nrdy);
    // The prime cycle was already sampled above, so RUN is 9 cycles on.
    check("reload_init_cycle", 32'(rise), 32'(9));
    check("reload_writes",     32'(nwe),  32'(8));
    check("reload_rdy",        32'(nrdy), 32'(0));
    @(negedge Clk);
    check("reload_read_rdy",   32'(cpu_rdy),   32'(1));
    check("reload_read_rdata", 32'(cpu_rdata), 32'(16'hA002));
    step();
    cpu_oe = 1'b0;

    // Reset pulsed after four load writes aborts at once; load restarts.
    step();
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    nwe = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (mem_we) nwe++;
    end
    check("abort_writes_before", 32'(nwe), 32'(4));
    step();
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    step();
    step();
    Reset_n = 1'b1;
    wait_load(rise, nwe, nrdy);
    check("abort_init_cycle", 32'(rise), 32'(10));
    check("abort_writes",     32'(nwe),  32'(8));
    step();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_sram_init_loader
